// File: rtl/vram_arbiter_if.sv
// Signal bundle between the display fetch path, the two writers, the frame RAM
// and vram_arbiter. The arbiter uses the slave view; the surrounding logic uses master.
interface vram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 12
);
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_vld;
  logic [DATA_W-1:0] pix_data;

  logic              w0_req;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;
  logic              w0_gnt;

  logic              w1_req;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;
  logic              w1_gnt;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Handshake: pix_req transfers one read per asserted cycle; a writer holds
  // wX_req/addr/data until it sees wX_gnt (one word per gnt pulse) and may drop
  // wX_req without a gnt to withdraw.
  modport slave (
    input  pix_req, pix_addr, w0_req, w0_addr, w0_data,
    input  w1_req, w1_addr, w1_data, ram_rdata,
    output pix_vld, pix_data, w0_gnt, w1_gnt,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output pix_req, pix_addr, w0_req, w0_addr, w0_data,
    output w1_req, w1_addr, w1_data, ram_rdata,
    input  pix_vld, pix_data, w0_gnt, w1_gnt,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port frame RAM arbiter: display reads always win, two writers share
// the leftover cycles round-robin with a burst cap. All RAM/grant outputs registered.
module vram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int BURST_MAX = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  vram_arbiter_if.slave        io_bus,
  output logic [1:0]           o_dbg_state
);
  typedef enum logic [1:0] {ST_IDLE, ST_DISP, ST_WR0, ST_WR1} state_t;

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_burst, w_burst_next;
  logic              r_rr, w_rr_next;          // 0: writer 0 preferred
  logic              r_sticky, w_sticky_next;  // current run began as a lone grant
  logic              w_sel, w_cur_wr, w_cur_sel, w_both;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_wdata_next;

  logic              r_ram_en, r_ram_we, r_gnt0, r_gnt1, r_pix_vld;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_pix_data;
  logic [RD_LAT:0]   r_vsr;

  assign w_cur_wr  = (r_state == ST_WR0) || (r_state == ST_WR1);
  assign w_cur_sel = (r_state == ST_WR1);
  assign w_both    = io_bus.w0_req && io_bus.w1_req;

  always_comb begin
    w_next        = ST_IDLE;
    w_sel         = 1'b0;
    w_rr_next     = r_rr;
    w_sticky_next = 1'b0;
    w_burst_next  = '0;
    w_addr_next   = r_ram_addr;
    w_wdata_next  = r_ram_wdata;
    if (io_bus.pix_req) begin
      w_next      = ST_DISP;
      w_addr_next = io_bus.pix_addr;
    end else if (w_both) begin
      // A run started by a lone writer may continue until the cap; otherwise alternate.
      if (w_cur_wr && (r_burst >= BURST_LIM)) begin
        w_sel = ~w_cur_sel;
      end else if (w_cur_wr && r_sticky) begin
        w_sel         = w_cur_sel;
        w_sticky_next = 1'b1;
      end else begin
        w_sel = r_rr;
      end
      w_rr_next = ~w_sel;
      w_next    = w_sel ? ST_WR1 : ST_WR0;
    end else if (io_bus.w0_req) begin
      w_sel         = 1'b0;
      w_sticky_next = 1'b1;
      w_next        = ST_WR0;
    end else if (io_bus.w1_req) begin
      w_sel         = 1'b1;
      w_sticky_next = 1'b1;
      w_next        = ST_WR1;
    end
    if ((w_next == ST_WR0) || (w_next == ST_WR1)) begin
      w_addr_next  = w_sel ? io_bus.w1_addr : io_bus.w0_addr;
      w_wdata_next = w_sel ? io_bus.w1_data : io_bus.w0_data;
      if (w_cur_wr && (w_sel == w_cur_sel))
        w_burst_next = (r_burst == BURST_LIM) ? r_burst : r_burst + 1'b1;
      else
        w_burst_next = CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_burst     <= '0;
      r_rr        <= 1'b0;
      r_sticky    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_vsr       <= '0;
      r_pix_vld   <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_burst     <= w_burst_next;
      r_rr        <= w_rr_next;
      r_sticky    <= w_sticky_next;
      r_ram_en    <= (w_next != ST_IDLE);
      r_ram_we    <= (w_next == ST_WR0) || (w_next == ST_WR1);
      r_ram_addr  <= w_addr_next;
      r_ram_wdata <= w_wdata_next;
      r_gnt0      <= (w_next == ST_WR0);
      r_gnt1      <= (w_next == ST_WR1);
      // Tag each read; the tag reaches the tail when RAM data is valid.
      r_vsr       <= {r_vsr[RD_LAT-1:0], (w_next == ST_DISP)};
      r_pix_vld   <= r_vsr[RD_LAT];
      if (r_vsr[RD_LAT])
        r_pix_data <= io_bus.ram_rdata;
    end
  end

  assign io_bus.ram_en    = r_ram_en;
  assign io_bus.ram_we    = r_ram_we;
  assign io_bus.ram_addr  = r_ram_addr;
  assign io_bus.ram_wdata = r_ram_wdata;
  assign io_bus.w0_gnt    = r_gnt0;
  assign io_bus.w1_gnt    = r_gnt1;
  assign io_bus.pix_vld   = r_pix_vld;
  assign io_bus.pix_data  = r_pix_data;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a vector table for single-cycle arbitration
// decisions plus hand-written sequences for streaming, bursts, preemption and reset.
module tb_vram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         k0 = 0;
  int         k1 = 0;

  vram_arbiter_if #(.ADDR_W(20), .DATA_W(12)) vif ();

  vram_arbiter #(.ADDR_W(20), .DATA_W(12), .RD_LAT(1), .BURST_MAX(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(vif.slave), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input int a);
    return 12'((a * 37 + 5) & 32'hfff);
  endfunction

  // RAM model with one cycle read latency; contents are pat(addr).
  always @(posedge clk) begin
    if (vif.ram_en && !vif.ram_we)
      vif.ram_rdata <= pat(int'(vif.ram_addr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    vif.pix_req = 1'b0; vif.pix_addr = '0;
    vif.w0_req = 1'b0; vif.w0_addr = '0; vif.w0_data = '0;
    vif.w1_req = 1'b0; vif.w1_addr = '0; vif.w1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k0 = 0; k1 = 0;
  endtask

  // One cycle of the writer protocol: present the next word, check the decision.
  task automatic step(input logic pix, input logic r0, input logic r1,
                      input logic e0, input logic e1, input string tag);
    logic [19:0] ea;
    logic [11:0] ed;
    vif.pix_req = pix; vif.pix_addr = 20'h70000;
    vif.w0_req = r0; vif.w0_addr = 20'h40000 + 20'(k0); vif.w0_data = 12'h400 + 12'(k0);
    vif.w1_req = r1; vif.w1_addr = 20'h50000 + 20'(k1); vif.w1_data = 12'h500 + 12'(k1);
    ea = e0 ? vif.w0_addr : vif.w1_addr;
    ed = e0 ? vif.w0_data : vif.w1_data;
    @(posedge clk); #1;
    chk({tag, "_gnt0"}, 32'(vif.w0_gnt), 32'(e0));
    chk({tag, "_gnt1"}, 32'(vif.w1_gnt), 32'(e1));
    if (e0 || e1) begin
      chk({tag, "_we"}, 32'(vif.ram_we), 32'd1);
      chk({tag, "_addr"}, 32'(vif.ram_addr), 32'(ea));
      chk({tag, "_wdata"}, 32'(vif.ram_wdata), 32'(ed));
    end else if (pix) begin
      chk({tag, "_rd_en"}, 32'(vif.ram_en), 32'd1);
      chk({tag, "_rd_we"}, 32'(vif.ram_we), 32'd0);
      chk({tag, "_rd_addr"}, 32'(vif.ram_addr), 32'h70000);
    end
    if (vif.w0_gnt) k0++;
    if (vif.w1_gnt) k1++;
  endtask

  typedef struct {
    logic pix; logic w0; logic w1;
    logic en; logic we; logic g0; logic g1;
    logic [19:0] addr; logic [11:0] wd;
  } vec_t;
  vec_t tbl[13];

  initial begin
    idle_inputs();

    // Reset with every request asserted: all outputs held at zero.
    vif.pix_req = 1'b1; vif.w0_req = 1'b1; vif.w1_req = 1'b1;
    vif.pix_addr = 20'h12345; vif.w0_addr = 20'h11111; vif.w1_addr = 20'h22222;
    vif.w0_data = 12'hABC; vif.w1_data = 12'hDEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_en", 32'(vif.ram_en), 0);
    chk("rst_ram_we", 32'(vif.ram_we), 0);
    chk("rst_ram_addr", 32'(vif.ram_addr), 0);
    chk("rst_ram_wdata", 32'(vif.ram_wdata), 0);
    chk("rst_gnt", 32'({vif.w0_gnt, vif.w1_gnt}), 0);
    chk("rst_pix_vld", 32'(vif.pix_vld), 0);
    chk("rst_pix_data", 32'(vif.pix_data), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_disp_state", 32'(dbg_state), 1);
    chk("rel_disp_en_we", 32'({vif.ram_en, vif.ram_we}), 32'b10);
    chk("rel_disp_addr", 32'(vif.ram_addr), 32'h12345);
    chk("rel_disp_gnt", 32'({vif.w0_gnt, vif.w1_gnt}), 0);

    // Arbitration table, applied back to back from reset.
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 20'h00000, 12'h000};
    tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 20'h80001, 12'h000};
    tbl[2]  = '{0, 0, 1, 1, 1, 0, 1, 20'hA0002, 12'h202};
    tbl[3]  = '{1, 1, 1, 1, 0, 0, 0, 20'h80003, 12'h000};
    tbl[4]  = '{0, 1, 1, 1, 1, 1, 0, 20'h90004, 12'h104};
    tbl[5]  = '{0, 1, 1, 1, 1, 0, 1, 20'hA0005, 12'h205};
    tbl[6]  = '{0, 1, 1, 1, 1, 1, 0, 20'h90006, 12'h106};
    tbl[7]  = '{0, 1, 0, 1, 1, 1, 0, 20'h90007, 12'h107};
    tbl[8]  = '{0, 1, 1, 1, 1, 1, 0, 20'h90008, 12'h108};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 20'h00000, 12'h000};
    tbl[10] = '{0, 1, 1, 1, 1, 0, 1, 20'hA000A, 12'h20A};
    tbl[11] = '{0, 0, 1, 1, 1, 0, 1, 20'hA000B, 12'h20B};
    tbl[12] = '{0, 1, 1, 1, 1, 0, 1, 20'hA000C, 12'h20C};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      vif.pix_req = tbl[i].pix; vif.pix_addr = 20'h80000 + 20'(i);
      vif.w0_req = tbl[i].w0; vif.w0_addr = 20'h90000 + 20'(i); vif.w0_data = 12'h100 + 12'(i);
      vif.w1_req = tbl[i].w1; vif.w1_addr = 20'hA0000 + 20'(i); vif.w1_data = 12'h200 + 12'(i);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_en", i), 32'(vif.ram_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_we", i), 32'(vif.ram_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_gnt", i), 32'({vif.w0_gnt, vif.w1_gnt}), 32'({tbl[i].g0, tbl[i].g1}));
      if (tbl[i].en) chk($sformatf("vec%0d_addr", i), 32'(vif.ram_addr), 32'(tbl[i].addr));
      if (tbl[i].we) chk($sformatf("vec%0d_wdata", i), 32'(vif.ram_wdata), 32'(tbl[i].wd));
    end

    // 1024 back-to-back reads with writer 0 waiting the whole time.
    do_reset();
    for (int c = 0; c < 1030; c++) begin
      vif.pix_req = (c < 1024); vif.pix_addr = 20'(c);
      vif.w0_req = 1'b1; vif.w0_addr = 20'h60000; vif.w0_data = 12'h600;
      @(posedge clk); #1;
      if (c < 1024) chk("stream_no_gnt", 32'({vif.w0_gnt, vif.w1_gnt}), 0);
      if (c >= 2 && c < 1026) begin
        chk("stream_vld", 32'(vif.pix_vld), 1);
        chk("stream_data", 32'(vif.pix_data), 32'(pat(c - 2)));
      end else begin
        chk("stream_vld_off", 32'(vif.pix_vld), 0);
        if (c >= 1026) chk("stream_data_hold", 32'(vif.pix_data), 32'(pat(1023)));
      end
    end

    // Both writers held: strict alternation starting with writer 0.
    do_reset();
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 1'b1, (n % 2) == 0, (n % 2) == 1, "alt");

    // Writer 0 alone, writer 1 joins on cycle 5: 16 straight then writer 1.
    do_reset();
    for (int n = 0; n < 17; n++) step(1'b0, 1'b1, n >= 5, n < 16, n == 16, "burst");
    chk("burst_w0_words", 32'(k0), 16);
    chk("burst_w1_words", 32'(k1), 1);

    // Display preempts writer 1 mid-burst; writer 1 resumes without loss.
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "pre_w1");
    for (int n = 0; n < 2; n++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "preempt");
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "resume");
    chk("resume_w1_words", 32'(k1), 7);

    // Reset one cycle after a read is issued: that read never returns.
    do_reset();
    vif.pix_req = 1'b1; vif.pix_addr = 20'h00005;
    @(posedge clk); #1;
    vif.pix_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("flush_ram_en", 32'(vif.ram_en), 0);
    chk("flush_state", 32'(dbg_state), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("flush_no_vld", 32'(vif.pix_vld), 0);
    end
    chk("flush_pix_data", 32'(vif.pix_data), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
